// File: rtl/rv32_instr_fetch_if.sv
// Bus bundle for the fetch stage: instruction-memory request/response,
// redirect from branch resolution, and the decode-facing entry stream.
interface rv32_instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    // fetch stage side
    modport master (
        output imem_req_valid, imem_req_addr,
        output out_valid, out_instr, out_pc, out_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, out_ready
    );

    // memory / redirect source / decode side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_instr, out_pc, out_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/rv32_instr_fetch.sv
// In-order RV32 instruction fetch: owns the PC, issues word requests,
// buffers {pc, instr} responses and hands them to decode. Redirects flush
// buffered work and drop stale in-flight responses; misaligned targets
// produce a single fault-marker entry.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_RUN       | normal fetch, requests issued while credit is available
// S_FLT_DRAIN | misaligned redirect seen, waiting for stale responses to drain
// S_FLT_HOLD  | fault marker pushed, idle until the next redirect
module rv32_instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    localparam int         CNT_W    = $clog2(DEPTH + 1)
) (
    input logic                clk,
    input logic                rst,
    rv32_instr_fetch_if.master bus
);
    localparam int          PTR_W = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_FLT_DRAIN = 2'd1,
        S_FLT_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic [PTR_W-1:0]   frd_q, frd_d;
    logic [PTR_W-1:0]   fwr_q, fwr_d;
    logic [PTR_W-1:0]   pqrd_q, pqrd_d;
    logic [PTR_W-1:0]   pqwr_q, pqwr_d;

    logic [31:0]        fifo_pc_q    [DEPTH];
    logic [31:0]        fifo_pc_d    [DEPTH];
    logic [31:0]        fifo_instr_q [DEPTH];
    logic [31:0]        fifo_instr_d [DEPTH];
    logic               fifo_fault_q [DEPTH];
    logic               fifo_fault_d [DEPTH];
    logic [31:0]        pq_q         [DEPTH];
    logic [31:0]        pq_d         [DEPTH];

    logic               out_valid_w;
    logic               pop;
    logic               push;
    logic               req_valid;
    logic               req_fire;
    logic               rsp;
    logic [CNT_W:0]     credit_used;

    assign rsp         = bus.imem_rsp_valid;
    assign out_valid_w = !rst && (fcnt_q != '0);
    assign pop         = out_valid_w && bus.out_ready && !bus.redirect_valid;

    // An entry popped this cycle frees its slot immediately, which is what
    // lets a 1-cycle memory sustain one instruction per cycle with DEPTH=2.
    assign credit_used = {1'b0, outst_q} + {1'b0, fcnt_q} - {{CNT_W{1'b0}}, pop};
    assign req_valid   = !rst && (state_q == S_RUN) && !bus.redirect_valid
                         && (credit_used < (CNT_W+1)'(DEPTH));
    assign req_fire    = req_valid && bus.imem_req_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = {pc_q[31:2], 2'b00};
    assign bus.out_valid      = out_valid_w;
    assign bus.out_pc         = fifo_pc_q[frd_q];
    assign bus.out_instr      = fifo_instr_q[frd_q];
    assign bus.out_fault      = out_valid_w && fifo_fault_q[frd_q];

    // Next-state for PC, counters, pointers, FSM and buffer contents.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_pc_d   = fault_pc_q;
        outst_d      = outst_q;
        drop_d       = drop_q;
        fcnt_d       = fcnt_q;
        frd_d        = frd_q;
        fwr_d        = fwr_q;
        pqrd_d       = pqrd_q;
        pqwr_d       = pqwr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        fifo_fault_d = fifo_fault_q;
        pq_d         = pq_q;
        push         = 1'b0;

        if (bus.redirect_valid) begin
            // Requests are masked this cycle, so every outstanding response
            // not returning right now is stale and must be dropped later.
            fcnt_d  = '0;
            frd_d   = '0;
            fwr_d   = '0;
            pqrd_d  = '0;
            pqwr_d  = '0;
            outst_d = outst_q - CNT_W'(rsp);
            drop_d  = outst_q - CNT_W'(rsp);
            if (bus.redirect_pc[1:0] == 2'b00) begin
                pc_d    = bus.redirect_pc;
                state_d = S_RUN;
            end else begin
                fault_pc_d = bus.redirect_pc;
                state_d    = S_FLT_DRAIN;
            end
        end else begin
            if (req_fire) begin
                pq_d[pqwr_q] = pc_q;
                pqwr_d       = pqwr_q + PTR_W'(1);
                pc_d         = pc_q + 32'd4;
            end

            if (rsp) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    push                 = 1'b1;
                    fifo_pc_d[fwr_q]     = pq_q[pqrd_q];
                    fifo_instr_d[fwr_q]  = bus.imem_rsp_data;
                    fifo_fault_d[fwr_q]  = 1'b0;
                    pqrd_d               = pqrd_q + PTR_W'(1);
                end
            end else if (state_q == S_FLT_DRAIN && drop_q == '0) begin
                push                 = 1'b1;
                fifo_pc_d[fwr_q]     = fault_pc_q;
                fifo_instr_d[fwr_q]  = NOP;
                fifo_fault_d[fwr_q]  = 1'b1;
                state_d              = S_FLT_HOLD;
            end

            outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(rsp);
            if (push) begin
                fwr_d = fwr_q + PTR_W'(1);
            end
            if (pop) begin
                frd_d = frd_q + PTR_W'(1);
            end
            fcnt_d = fcnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control registers with synchronous reset; also guards against overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            fault_pc_q <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            fcnt_q     <= '0;
            frd_q      <= '0;
            fwr_q      <= '0;
            pqrd_q     <= '0;
            pqwr_q     <= '0;
        end else begin
            assert (!(push && !pop && fcnt_q == CNT_W'(DEPTH)));
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            fcnt_q     <= fcnt_d;
            frd_q      <= frd_d;
            fwr_q      <= fwr_d;
            pqrd_q     <= pqrd_d;
            pqwr_q     <= pqwr_d;
        end
    end

    // Buffer storage; contents are qualified by the counters, so no reset.
    always_ff @(posedge clk) begin
        fifo_pc_q    <= fifo_pc_d;
        fifo_instr_q <= fifo_instr_d;
        fifo_fault_q <= fifo_fault_d;
        pq_q         <= pq_d;
    end
endmodule

// File: tb/tb_rv32_instr_fetch.sv
// Directed bench for rv32_instr_fetch: a per-cycle vector table for steady
// streaming with backpressure and request stalls, plus hand-written
// sequences for redirects, misaligned-target faults and mid-stream reset.
module tb_rv32_instr_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32_instr_fetch_if bus_if ();

    rv32_instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks   = 0;
    int failures = 0;
    int lat      = 1;
    int cyc      = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    logic        s_fire;
    logic        s_rsp;
    logic [31:0] s_addr;
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];
    logic        pop_fault[$];
    logic [31:0] fire_addr[$];

    typedef struct {
        logic        ready;
        logic        req_ready;
        logic        e_req_v;
        logic [31:0] e_addr;
        logic        e_out_v;
        logic [31:0] e_out_pc;
    } vec_t;
    vec_t tbl[14];

    function automatic logic [31:0] image(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Observe the cycle just before the rising edge.
    task automatic sample();
        @(negedge clk);
        s_fire = bus_if.imem_req_valid && bus_if.imem_req_ready;
        s_addr = bus_if.imem_req_addr;
        s_rsp  = bus_if.imem_rsp_valid;
        if (s_fire) fire_addr.push_back(s_addr);
        if (bus_if.out_valid && bus_if.out_ready) begin
            pop_pc.push_back(bus_if.out_pc);
            pop_instr.push_back(bus_if.out_instr);
            pop_fault.push_back(bus_if.out_fault);
        end
    endtask

    // Advance one edge and update the in-order fixed-latency memory model.
    task automatic commit();
        @(posedge clk);
        #1;
        if (s_rsp) void'(mq.pop_front());
        if (s_fire) mq.push_back('{s_addr, cyc + lat});
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus_if.imem_rsp_valid = 1'b1;
            bus_if.imem_rsp_data  = image(mq[0].addr);
        end else begin
            bus_if.imem_rsp_valid = 1'b0;
            bus_if.imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic step();
        sample();
        commit();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0;
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rsp_data  = 32'h0;
        mq.delete();
        s_fire = 1'b0;
        s_rsp  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst req_valid", bus_if.imem_req_valid, 0);
        check("rst out_valid", bus_if.out_valid, 0);
        check("rst out_fault", bus_if.out_fault, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        mq.delete();
        pop_pc.delete();
        pop_instr.delete();
        pop_fault.delete();
        fire_addr.delete();
    endtask

    task automatic run_collect(input int npop, input int budget, input string tag);
        int k = 0;
        while (pop_pc.size() < npop && k < budget) begin
            step();
            k++;
        end
        check({tag, " pop_count"}, pop_pc.size() >= npop, 1);
    endtask

    task automatic check_pop(input string tag, input int idx, input logic [31:0] pc,
                             input logic [31:0] instr, input logic fault);
        if (pop_pc.size() > idx) begin
            check($sformatf("%s pop%0d pc", tag, idx), pop_pc[idx], pc);
            check($sformatf("%s pop%0d instr", tag, idx), pop_instr[idx], instr);
            check($sformatf("%s pop%0d fault", tag, idx), pop_fault[idx], fault);
        end else begin
            check($sformatf("%s pop%0d present", tag, idx), 0, 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_if.imem_req_ready = 1'b1;
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rsp_data  = 32'h0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0;
        bus_if.out_ready      = 1'b1;

        // ready, req_ready, exp req_valid, exp addr, exp out_valid, exp out_pc
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h18};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h1C};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b0, 32'h00};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h20};

        // Streaming table, 1-cycle memory.
        lat = 1;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            bus_if.out_ready      = tbl[i].ready;
            bus_if.imem_req_ready = tbl[i].req_ready;
            sample();
            check($sformatf("v%0d req_valid", i), bus_if.imem_req_valid, tbl[i].e_req_v);
            if (tbl[i].e_req_v)
                check($sformatf("v%0d req_addr", i), bus_if.imem_req_addr, tbl[i].e_addr);
            check($sformatf("v%0d out_valid", i), bus_if.out_valid, tbl[i].e_out_v);
            if (tbl[i].e_out_v) begin
                check($sformatf("v%0d out_pc", i), bus_if.out_pc, tbl[i].e_out_pc);
                check($sformatf("v%0d out_instr", i), bus_if.out_instr, image(tbl[i].e_out_pc));
                check($sformatf("v%0d out_fault", i), bus_if.out_fault, 0);
            end
            commit();
        end
        bus_if.imem_req_ready = 1'b1;

        // Decode stalled from the start: exactly DEPTH requests, then drain in order.
        lat = 1;
        bus_if.out_ready = 1'b0;
        do_reset();
        repeat (6) step();
        check("A fire_count", fire_addr.size(), 2);
        if (fire_addr.size() >= 2) begin
            check("A fire0", fire_addr[0], 32'h0);
            check("A fire1", fire_addr[1], 32'h4);
        end
        check("A req_valid held", bus_if.imem_req_valid, 0);
        bus_if.out_ready = 1'b1;
        run_collect(5, 30, "A");
        for (int i = 0; i < 5; i++)
            check_pop("A", i, 32'(i * 4), image(32'(i * 4)), 1'b0);

        // 3-cycle memory, two requests in flight, redirect to 0x100.
        lat = 3;
        bus_if.out_ready = 1'b1;
        do_reset();
        step();
        step();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h100;
        step();
        bus_if.redirect_valid = 1'b0;
        run_collect(2, 40, "B");
        check_pop("B", 0, 32'h100, image(32'h100), 1'b0);
        check_pop("B", 1, 32'h104, image(32'h104), 1'b0);
        if (fire_addr.size() >= 3)
            check("B fire after redirect", fire_addr[2], 32'h100);
        else
            check("B fire count", fire_addr.size(), 3);

        // Redirect coinciding with a response and a pending pop.
        lat = 1;
        bus_if.out_ready = 1'b1;
        do_reset();
        repeat (3) step();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h300;
        sample();
        check("C pre out_valid", bus_if.out_valid, 1);
        check("C pre out_pc", bus_if.out_pc, 32'h4);
        commit();
        bus_if.redirect_valid = 1'b0;
        pop_pc.delete();
        pop_instr.delete();
        pop_fault.delete();
        sample();
        check("C flushed out_valid", bus_if.out_valid, 0);
        commit();
        run_collect(2, 30, "C");
        check_pop("C", 0, 32'h300, image(32'h300), 1'b0);
        check_pop("C", 1, 32'h304, image(32'h304), 1'b0);

        // Misaligned redirect with one response outstanding.
        lat = 3;
        bus_if.out_ready = 1'b1;
        do_reset();
        step();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h102;
        step();
        bus_if.redirect_valid = 1'b0;
        fire_addr.delete();
        run_collect(1, 20, "D");
        check_pop("D", 0, 32'h102, 32'h0000_0013, 1'b1);
        repeat (6) step();
        check("D single fault entry", pop_pc.size(), 1);
        check("D no requests", fire_addr.size(), 0);
        check("D idle out_valid", bus_if.out_valid, 0);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h200;
        step();
        bus_if.redirect_valid = 1'b0;
        pop_pc.delete();
        pop_instr.delete();
        pop_fault.delete();
        run_collect(2, 30, "D2");
        check_pop("D2", 0, 32'h200, image(32'h200), 1'b0);
        check_pop("D2", 1, 32'h204, image(32'h204), 1'b0);
        if (fire_addr.size() >= 1)
            check("D2 first fire", fire_addr[0], 32'h200);
        else
            check("D2 fire count", fire_addr.size(), 1);

        // Reset while the buffer is full, then refetch from the reset PC.
        lat = 1;
        bus_if.out_ready = 1'b0;
        do_reset();
        repeat (4) step();
        check("E full out_valid", bus_if.out_valid, 1);
        check("E full req_valid", bus_if.imem_req_valid, 0);
        do_reset();
        bus_if.out_ready = 1'b1;
        run_collect(2, 20, "E");
        check_pop("E", 0, 32'h0, image(32'h0), 1'b0);
        check_pop("E", 1, 32'h4, image(32'h4), 1'b0);
        if (fire_addr.size() >= 1)
            check("E first fire", fire_addr[0], 32'h0);
        else
            check("E fire count", fire_addr.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
